// File: rtl/mdio_responder.sv
// mdio_responder: Clause 22 MDIO management responder (PHY side).
// Decodes read/write frames addressed to PHY_ADDR and maps them onto a
// 32x16 register access port.
// Ports:
//   clk, rst               system clock, synchronous active-high reset
//   mdc, mdio_i            management clock / pad input (async to clk)
//   mdio_o, mdio_oe        pad output value / output enable
//   reg_addr               register address from REGAD decode
//   reg_rd, reg_rdata      1-clk read strobe; data valid the clk after
//   reg_wr, reg_wdata      1-clk write strobe with data
//   frame_err              1-clk pulse on a malformed frame
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int          PREAMBLE_LEN = 32,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic [4:0]  reg_addr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        reg_wr,
  output logic [15:0] reg_wdata,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    S_PRE, S_ST1, S_OP, S_PHY, S_REG, S_TA, S_DATA
  } state_t;

  localparam logic [5:0] PRE_LEN = 6'(PREAMBLE_LEN);

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_mdc_sync;
  logic [SYNC_STAGES-1:0] r_mdio_sync;
  logic                   r_mdc_d;
  logic [5:0]             r_ones;
  logic [3:0]             r_cnt;
  logic                   r_op0;
  logic                   r_is_rd;
  logic [4:0]             r_phy;
  logic [3:0]             r_regsh;
  logic [15:0]            r_shift;
  logic                   r_rd_d;
  logic                   r_mdio_o;
  logic                   r_mdio_oe;
  logic [4:0]             r_addr;
  logic                   r_reg_rd;
  logic                   r_reg_wr;
  logic [15:0]            r_wdata;
  logic                   r_frame_err;

  logic w_rise;
  logic w_bit;

  // mdc and mdio share the same synchroniser depth so the sampled bit lines
  // up with the detected rise.
  assign w_rise = r_mdc_sync[SYNC_STAGES-1] & ~r_mdc_d;
  assign w_bit  = r_mdio_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronisers reset high so an idle-high mdc gives no false rise.
      r_mdc_sync  <= '1;
      r_mdio_sync <= '1;
      r_mdc_d     <= 1'b1;
      r_state     <= S_PRE;
      r_ones      <= '0;
      r_cnt       <= '0;
      r_op0       <= 1'b0;
      r_is_rd     <= 1'b0;
      r_phy       <= '0;
      r_regsh     <= '0;
      r_shift     <= '0;
      r_rd_d      <= 1'b0;
      r_mdio_o    <= 1'b1;
      r_mdio_oe   <= 1'b0;
      r_addr      <= '0;
      r_reg_rd    <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_wdata     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_mdc_sync  <= {r_mdc_sync[SYNC_STAGES-2:0], mdc};
      r_mdio_sync <= {r_mdio_sync[SYNC_STAGES-2:0], mdio_i};
      r_mdc_d     <= r_mdc_sync[SYNC_STAGES-1];
      r_reg_rd    <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_frame_err <= 1'b0;

      // Register file answers one clk after the strobe; capture it then.
      r_rd_d <= r_reg_rd;
      if (r_rd_d) r_shift <= reg_rdata;

      if (w_rise) begin
        unique case (r_state)
          // r_ones is only modified here and cleared when leaving, so it is
          // always zero on re-entry to PRE.
          S_PRE: begin
            if (w_bit) begin
              if (r_ones != 6'd63) r_ones <= r_ones + 6'd1;
            end else begin
              if (r_ones >= PRE_LEN) r_state <= S_ST1;
              r_ones <= '0;
            end
          end
          S_ST1: begin
            r_cnt <= '0;
            if (w_bit) r_state <= S_OP;
            else begin
              r_frame_err <= 1'b1;
              r_state     <= S_PRE;
            end
          end
          S_OP: begin
            if (r_cnt == 4'd0) begin
              r_op0 <= w_bit;
              r_cnt <= 4'd1;
            end else if (r_op0 != w_bit) begin
              r_is_rd <= r_op0;  // 10 = read, 01 = write
              r_cnt   <= '0;
              r_state <= S_PHY;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_PRE;
            end
          end
          S_PHY: begin
            r_phy <= {r_phy[3:0], w_bit};
            if (r_cnt == 4'd4) begin
              r_cnt   <= '0;
              r_state <= S_REG;
            end else r_cnt <= r_cnt + 4'd1;
          end
          S_REG: begin
            r_regsh <= {r_regsh[2:0], w_bit};
            if (r_cnt == 4'd4) begin
              // R0: last REGAD bit
              r_addr <= {r_regsh, w_bit};
              r_cnt  <= '0;
              if (r_phy != PHY_ADDR) r_state <= S_PRE;
              else begin
                r_state <= S_TA;
                if (r_is_rd) r_reg_rd <= 1'b1;
              end
            end else r_cnt <= r_cnt + 4'd1;
          end
          S_TA: begin
            if (r_cnt == 4'd0) begin
              // R1
              if (r_is_rd) begin
                r_mdio_oe <= 1'b1;
                r_mdio_o  <= 1'b0;
                r_cnt     <= 4'd1;
              end else if (!w_bit) begin
                r_frame_err <= 1'b1;
                r_state     <= S_PRE;
              end else r_cnt <= 4'd1;
            end else begin
              // R2: read starts presenting D15 for the initiator to sample at R3
              r_cnt <= '0;
              if (r_is_rd) begin
                r_mdio_o <= r_shift[15];
                r_shift  <= {r_shift[14:0], 1'b0};
                r_state  <= S_DATA;
              end else if (w_bit) begin
                r_frame_err <= 1'b1;
                r_state     <= S_PRE;
              end else r_state <= S_DATA;
            end
          end
          S_DATA: begin
            // r_cnt = k-3 for rise Rk
            if (r_is_rd) begin
              if (r_cnt == 4'd15) begin
                r_mdio_oe <= 1'b0;
                r_mdio_o  <= 1'b1;
                r_state   <= S_PRE;
              end else begin
                r_mdio_o <= r_shift[15];
                r_shift  <= {r_shift[14:0], 1'b0};
                r_cnt    <= r_cnt + 4'd1;
              end
            end else begin
              r_shift <= {r_shift[14:0], w_bit};
              if (r_cnt == 4'd15) begin
                r_wdata  <= {r_shift[14:0], w_bit};
                r_reg_wr <= 1'b1;
                r_state  <= S_PRE;
              end else r_cnt <= r_cnt + 4'd1;
            end
          end
          default: r_state <= S_PRE;
        endcase
      end
    end
  end

  assign mdio_o    = r_mdio_o;
  assign mdio_oe   = r_mdio_oe;
  assign reg_addr  = r_addr;
  assign reg_rd    = r_reg_rd;
  assign reg_wr    = r_reg_wr;
  assign reg_wdata = r_wdata;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: bit-banged MDIO initiator plus a scoreboard of
// expected register-port strobes checked by an independent monitor.
module tb_mdio_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mdc = 1'b0;
  logic        r_drv = 1'b1;
  logic        mdio_o, mdio_oe;
  logic [4:0]  reg_addr;
  logic        reg_rd, reg_wr, frame_err;
  logic [15:0] reg_rdata, reg_wdata;
  logic        w_line;

  int n_chk = 0;
  int n_err = 0;
  logic oe_seen = 1'b0;

  // open-drain style bus with pull-up when nobody drives
  assign w_line = mdio_oe ? mdio_o : r_drv;

  mdio_responder #(.PHY_ADDR(5'd1), .PREAMBLE_LEN(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .mdc(mdc), .mdio_i(w_line),
    .mdio_o(mdio_o), .mdio_oe(mdio_oe), .reg_addr(reg_addr),
    .reg_rd(reg_rd), .reg_rdata(reg_rdata), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // register file model: data valid the clk after reg_rd
  logic [15:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    mem[2] = 16'hA5C3;
    mem[9] = 16'h3C5A;
  end
  always @(posedge clk) if (reg_rd) reg_rdata <= mem[reg_addr];

  always @(posedge clk) if (mdio_oe === 1'b1) oe_seen = 1'b1;

  typedef struct packed {
    logic [2:0]  kind;  // {frame_err, reg_wr, reg_rd}
    logic [4:0]  addr;
    logic [15:0] data;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // monitor: every strobe cycle must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && (reg_rd || reg_wr || frame_err)) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_strobe act=%b exp=none", {frame_err, reg_wr, reg_rd});
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_kind", {29'd0, frame_err, reg_wr, reg_rd}, {29'd0, e.kind});
        if (e.kind != 3'b100) chk("reg_addr", {27'd0, reg_addr}, {27'd0, e.addr});
        if (e.kind == 3'b010) chk("reg_wdata", {16'd0, reg_wdata}, {16'd0, e.data});
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one MDC period; s = line value just before the rise
  task automatic mbit(input logic b, output logic s);
    mdc = 1'b0;
    r_drv = b;
    wclk(8);
    s = w_line;
    mdc = 1'b1;
    wclk(8);
  endtask

  task automatic send(input logic [15:0] v, input int n);
    logic s;
    for (int i = n - 1; i >= 0; i--) mbit(v[i], s);
  endtask

  task automatic rd_frame(input int pre, input logic [4:0] phy, input logic [4:0] ra,
                          input logic serve, input logic [15:0] exp, input int abort_k);
    logic s, ta_s;
    logic [15:0] got;
    exp_t e;
    ta_s = 1'b1;
    got = '0;
    if (serve) begin
      e.kind = 3'b001; e.addr = ra; e.data = '0;
      q.push_back(e);
    end
    oe_seen = 1'b0;
    for (int i = 0; i < pre; i++) mbit(1'b1, s);
    send(16'b01, 2);
    send(16'b10, 2);
    send({11'd0, phy}, 5);
    send({11'd0, ra}, 5);
    for (int k = 1; k <= 18; k++) begin
      mbit(1'b1, s);
      if (k == 2) ta_s = s;
      if (k >= 3) got[18-k] = s;
      if (abort_k == k) begin
        chk("oe_before_rst", {31'd0, mdio_oe}, 32'd1);
        rst = 1'b1;
        wclk(1);
        chk("rst_oe", {31'd0, mdio_oe}, 32'd0);
        chk("rst_o", {31'd0, mdio_o}, 32'd1);
        rst = 1'b0;
        wclk(2);
        return;
      end
    end
    wclk(4);
    if (serve) begin
      chk("ta2_driven0", {31'd0, ta_s}, 32'd0);
      chk("rd_data", {16'd0, got}, {16'd0, exp});
      chk("oe_after_r18", {31'd0, mdio_oe}, 32'd0);
      chk("o_after_r18", {31'd0, mdio_o}, 32'd1);
      chk("oe_seen_rd", {31'd0, oe_seen}, 32'd1);
    end else begin
      chk("oe_never_ign", {31'd0, oe_seen}, 32'd0);
    end
  endtask

  // kind: 0 none, 1 write strobe, 2 frame_err
  task automatic wr_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] ra, input logic [1:0] ta,
                          input logic [15:0] d, input int kind);
    logic s;
    exp_t e;
    if (kind == 1) begin
      e.kind = 3'b010; e.addr = ra; e.data = d;
      q.push_back(e);
    end else if (kind == 2) begin
      e.kind = 3'b100; e.addr = '0; e.data = '0;
      q.push_back(e);
    end
    oe_seen = 1'b0;
    for (int i = 0; i < pre; i++) mbit(1'b1, s);
    send(16'b01, 2);
    send({14'd0, op}, 2);
    send({11'd0, phy}, 5);
    send({11'd0, ra}, 5);
    send({14'd0, ta}, 2);
    send(d, 16);
    r_drv = 1'b1;
    wclk(4);
    chk("oe_never_wr", {31'd0, oe_seen}, 32'd0);
  endtask

  initial begin
    wclk(5);
    chk("rst_mdio_oe", {31'd0, mdio_oe}, 32'd0);
    chk("rst_mdio_o", {31'd0, mdio_o}, 32'd1);
    chk("rst_reg_addr", {27'd0, reg_addr}, 32'd0);
    chk("rst_reg_rd", {31'd0, reg_rd}, 32'd0);
    chk("rst_reg_wr", {31'd0, reg_wr}, 32'd0);
    chk("rst_reg_wdata", {16'd0, reg_wdata}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    wclk(4);

    // served read, PHYAD=1 REGAD=2
    rd_frame(32, 5'd1, 5'd2, 1'b1, 16'hA5C3, 0);
    // served write, REGAD=0 data 8000
    wr_frame(32, 2'b01, 5'd1, 5'd0, 2'b10, 16'h8000, 1);
    // write to highest register
    wr_frame(32, 2'b01, 5'd1, 5'd31, 2'b10, 16'h5A5A, 1);
    // read for another PHY: silent
    rd_frame(32, 5'd4, 5'd2, 1'b0, 16'h0000, 0);
    // write with bad turnaround
    wr_frame(32, 2'b01, 5'd1, 5'd5, 2'b11, 16'h00F0, 2);
    // OP=11
    wr_frame(32, 2'b11, 5'd1, 5'd5, 2'b10, 16'h1230, 2);
    // 31-bit preamble: ignored, next full-preamble frame served
    rd_frame(31, 5'd1, 5'd2, 1'b0, 16'h0000, 0);
    rd_frame(32, 5'd1, 5'd9, 1'b1, 16'h3C5A, 0);
    // reset during read data, then a clean read
    rd_frame(32, 5'd1, 5'd2, 1'b1, 16'hA5C3, 8);
    rd_frame(32, 5'd1, 5'd9, 1'b1, 16'h3C5A, 0);

    wclk(20);
    chk("sb_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
